// File: rtl/lvds_deser_bitslip_if.sv
// Parallel-side bundle of the LVDS receiver: serial lane pins, word output,
// bitslip request and the delay-tap control/readback bus.
`timescale 1ns/1ps
interface lvds_deser_bitslip_if #(
    parameter int N_LANES  = 1,
    parameter int DW       = 8,
    parameter int TAP_BITS = 5
);
    logic [N_LANES-1:0]    lvds_data_p;
    logic [N_LANES-1:0]    lvds_data_n;
    logic [N_LANES*DW-1:0] data_outs;
    logic                  bitslip;
    logic                  sample_clk;
    logic [31:0]           pd_int_period;
    logic                  id_auto_control;
    logic                  id_mux;
    logic                  id_inc;
    logic                  id_dec;
    logic [TAP_BITS-1:0]   id_value;

    // No valid/ready pair: data_outs is a new word on every sample_clk rise and
    // holds for a full sample_clk period; bitslip is a level sampled on dco_p
    // whose rising edge is the request, with no acknowledge.
    modport master (
        output lvds_data_p, lvds_data_n, bitslip, pd_int_period,
               id_auto_control, id_mux, id_inc, id_dec,
        input  data_outs, sample_clk, id_value
    );

    modport slave (
        input  lvds_data_p, lvds_data_n, bitslip, pd_int_period,
               id_auto_control, id_mux, id_inc, id_dec,
        output data_outs, sample_clk, id_value
    );
endinterface

// File: rtl/lvds_deser_bitslip.sv
// LVDS receive front end: MSB-first deserialiser with one-bit bitslip, divided
// word clock, bang-bang phase detector and per-lane input-delay tap control.
`timescale 1ns/1ps
module lvds_deser_bitslip #(
    parameter int N_LANES  = 1,
    parameter int DW       = 8,
    parameter int TAP_BITS = 5,
    parameter int TAP_INIT = 16
) (
    input  logic                  dco_p,
    input  logic                  dco_n,
    input  logic                  pll_reset_n,
    lvds_deser_bitslip_if.slave   bus
);
    localparam int CNT_W = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DW - 1);
    localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(DW / 2);
    localparam logic [TAP_BITS-1:0] TAP_MAX  = {TAP_BITS{1'b1}};
    localparam logic [TAP_BITS-1:0] TAP_RST  = TAP_BITS'(TAP_INIT);
    localparam logic signed [15:0]  ACC_MAX  = 16'sh7fff;
    localparam logic signed [15:0]  ACC_MIN  = -16'sh8000;

    logic unused_pins;
    assign unused_pins = dco_n;

    // Differential legs that agree carry no valid level and read as 0.
    logic [N_LANES-1:0] lane_bit;
    assign lane_bit = bus.lvds_data_p & ~bus.lvds_data_n;

    // ---------------- state ----------------
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                hold_q, hold_d;
    logic                sample_clk_q, sample_clk_d;
    logic [DW-1:0]       sr_q   [N_LANES];
    logic [DW-1:0]       sr_d   [N_LANES];
    logic [DW-1:0]       data_q [N_LANES];
    logic [DW-1:0]       data_d [N_LANES];
    logic                bs_q, bs_d;
    logic                bs_prev_q, bs_prev_d;
    logic                pending_q, pending_d;

    logic [N_LANES-1:0]  mid_q, mid_d;
    logic [N_LANES-1:0]  d_q, d_d;
    logic signed [15:0]  acc_q   [N_LANES];
    logic signed [15:0]  acc_d   [N_LANES];
    logic signed [15:0]  acc_upd [N_LANES];
    logic [31:0]         pcnt_q, pcnt_d;
    logic [TAP_BITS-1:0] tap_q [N_LANES];
    logic [TAP_BITS-1:0] tap_d [N_LANES];

    logic inc_s1_q, inc_s1_d, inc_s2_q, inc_s2_d, inc_prev_q, inc_prev_d;
    logic dec_s1_q, dec_s1_d, dec_s2_q, dec_s2_d, dec_prev_q, dec_prev_d;

    logic        cnt_last;
    logic        bs_edge;
    logic        inc_edge;
    logic        dec_edge;
    logic [31:0] pd_limit;
    logic        period_end;

    // ---------------- deserialiser and bitslip ----------------
    always_comb begin
        cnt_last  = (cnt_q == CNT_LAST);
        bs_d      = bus.bitslip;
        bs_prev_d = bs_q;
        bs_edge   = bs_q & ~bs_prev_q;
        hold_d    = 1'b0;
        pending_d = pending_q;
        cnt_d     = cnt_q + CNT_W'(1);

        // The slipped frame wraps normally, then idles at 0 for one bit so it
        // spans DW+1 bits and drops the oldest bit of the next word.
        if (cnt_last) begin
            cnt_d  = '0;
            hold_d = pending_q;
        end else if (hold_q) begin
            cnt_d  = cnt_q;
        end

        // Edges that land while a slip is still pending are discarded.
        if (pending_q) begin
            pending_d = ~cnt_last;
        end else begin
            pending_d = bs_edge;
        end

        sample_clk_d = (cnt_d < CNT_HALF);

        for (int k = 0; k < N_LANES; k++) begin
            sr_d[k]   = {sr_q[k][DW-2:0], lane_bit[k]};
            data_d[k] = data_q[k];
            if (cnt_last) begin
                data_d[k] = sr_d[k];
            end
        end
    end

    // ---------------- phase detector and tap control ----------------
    always_comb begin
        mid_d      = lane_bit;
        d_d        = lane_bit;
        inc_s1_d   = bus.id_inc;
        inc_s2_d   = inc_s1_q;
        inc_prev_d = inc_s2_q;
        dec_s1_d   = bus.id_dec;
        dec_s2_d   = dec_s1_q;
        dec_prev_d = dec_s2_q;
        inc_edge   = inc_s2_q & ~inc_prev_q;
        dec_edge   = dec_s2_q & ~dec_prev_q;

        pd_limit   = (bus.pd_int_period == 32'd0) ? 32'd1 : bus.pd_int_period;
        // >= rather than == so a period shortened on the fly still terminates.
        period_end = (pcnt_q >= pd_limit - 32'd1);
        pcnt_d     = period_end ? 32'd0 : pcnt_q + 32'd1;

        for (int k = 0; k < N_LANES; k++) begin
            acc_upd[k] = acc_q[k];
            // Mid-bit sample still equal to the old bit means the edge came
            // late relative to our sampling point: vote +1, else -1.
            if (lane_bit[k] != d_q[k]) begin
                if (mid_q[k] == d_q[k]) begin
                    if (acc_q[k] != ACC_MAX) begin
                        acc_upd[k] = acc_q[k] + 16'sd1;
                    end
                end else if (acc_q[k] != ACC_MIN) begin
                    acc_upd[k] = acc_q[k] - 16'sd1;
                end
            end
            acc_d[k] = period_end ? 16'sd0 : acc_upd[k];

            tap_d[k] = tap_q[k];
            if (bus.id_auto_control) begin
                if (period_end) begin
                    if (acc_upd[k] > 16'sd0 && tap_q[k] != TAP_MAX) begin
                        tap_d[k] = tap_q[k] + TAP_BITS'(1);
                    end else if (acc_upd[k] < 16'sd0 && tap_q[k] != '0) begin
                        tap_d[k] = tap_q[k] - TAP_BITS'(1);
                    end
                end
            end else if (k == int'(bus.id_mux)) begin
                if (inc_edge && !dec_edge && tap_q[k] != TAP_MAX) begin
                    tap_d[k] = tap_q[k] + TAP_BITS'(1);
                end else if (dec_edge && !inc_edge && tap_q[k] != '0) begin
                    tap_d[k] = tap_q[k] - TAP_BITS'(1);
                end
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge dco_p or negedge pll_reset_n) begin
        if (!pll_reset_n) begin
            cnt_q        <= '0;
            hold_q       <= 1'b0;
            sample_clk_q <= 1'b0;
            bs_q         <= 1'b0;
            bs_prev_q    <= 1'b0;
            pending_q    <= 1'b0;
            d_q          <= '0;
            pcnt_q       <= '0;
            inc_s1_q     <= 1'b0;
            inc_s2_q     <= 1'b0;
            inc_prev_q   <= 1'b0;
            dec_s1_q     <= 1'b0;
            dec_s2_q     <= 1'b0;
            dec_prev_q   <= 1'b0;
            for (int k = 0; k < N_LANES; k++) begin
                sr_q[k]   <= '0;
                data_q[k] <= '0;
                acc_q[k]  <= '0;
                tap_q[k]  <= TAP_RST;
            end
        end else begin
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            sample_clk_q <= sample_clk_d;
            bs_q         <= bs_d;
            bs_prev_q    <= bs_prev_d;
            pending_q    <= pending_d;
            d_q          <= d_d;
            pcnt_q       <= pcnt_d;
            inc_s1_q     <= inc_s1_d;
            inc_s2_q     <= inc_s2_d;
            inc_prev_q   <= inc_prev_d;
            dec_s1_q     <= dec_s1_d;
            dec_s2_q     <= dec_s2_d;
            dec_prev_q   <= dec_prev_d;
            for (int k = 0; k < N_LANES; k++) begin
                sr_q[k]   <= sr_d[k];
                data_q[k] <= data_d[k];
                acc_q[k]  <= acc_d[k];
                tap_q[k]  <= tap_d[k];
            end
        end
    end

    // Mid-bit phase sample, half a bit period ahead of the data sample.
    always_ff @(negedge dco_p or negedge pll_reset_n) begin
        if (!pll_reset_n) begin
            mid_q <= '0;
        end else begin
            mid_q <= mid_d;
        end
    end

    // ---------------- outputs ----------------
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane_out
        assign bus.data_outs[g*DW +: DW] = data_q[g];
    end

    assign bus.sample_clk = sample_clk_q;

    always_comb begin
        bus.id_value = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (k == int'(bus.id_mux)) begin
                bus.id_value = tap_q[k];
            end
        end
    end
endmodule

// File: tb/tb_lvds_deser_bitslip.sv
// Directed bench for lvds_deser_bitslip: reset, alignment, bitslip rotation,
// auto phase tracking, manual tap control and reset with a slip pending.
`timescale 1ns/1ps
module tb_lvds_deser_bitslip;
  logic dco_p = 1'b0;
  logic dco_n;
  logic pll_reset_n;
  logic leg_eq;
  logic b, prev;
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 dco_p = ~dco_p;
  assign dco_n = ~dco_p;

  lvds_deser_bitslip_if #(.N_LANES(1), .DW(8), .TAP_BITS(5)) bus ();

  lvds_deser_bitslip #(.N_LANES(1), .DW(8), .TAP_BITS(5), .TAP_INIT(16)) dut (
    .dco_p       (dco_p),
    .dco_n       (dco_n),
    .pll_reset_n (pll_reset_n),
    .bus         (bus.slave)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_lane(input logic v);
    bus.lvds_data_p = v;
    bus.lvds_data_n = leg_eq ? v : ~v;
  endtask

  // Drive m around the falling edge, then the data bit for the next rising
  // edge; returns 1 time unit after that rising edge.
  task automatic send_bit(input logic bv, input logic mv);
    set_lane(mv);
    @(negedge dco_p);
    #1 set_lane(bv);
    @(posedge dco_p);
    #1;
  endtask

  task automatic do_reset();
    pll_reset_n = 1'b0;
    bus.bitslip = 1'b0;
    repeat (3) begin
      @(posedge dco_p);
      #1 set_lane(~bus.lvds_data_p);
    end
    check_eq("rst_data", 32'(bus.data_outs), 32'h00);
    check_eq("rst_sclk", 32'(bus.sample_clk), 32'h0);
    check_eq("rst_tap", 32'(bus.id_value), 32'd16);
    pll_reset_n = 1'b1;
  endtask

  task automatic pulse_id(input logic inc, input logic dec);
    bus.id_inc = inc;
    bus.id_dec = dec;
    repeat (4) @(posedge dco_p);
    #1;
    bus.id_inc = 1'b0;
    bus.id_dec = 1'b0;
    repeat (4) @(posedge dco_p);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    leg_eq              = 1'b0;
    bus.bitslip         = 1'b0;
    bus.pd_int_period   = 32'd64;
    bus.id_auto_control = 1'b0;
    bus.id_mux          = 1'b0;
    bus.id_inc          = 1'b0;
    bus.id_dec          = 1'b0;
    set_lane(1'b0);

    // Alignment then bitslip: pattern 0,0,0,0,0,0,1,0 with bit n on edge n.
    do_reset();
    for (int n = 1; n <= 262; n++) begin
      b = (((n - 1) % 8) == 6);
      send_bit(b, b);
      case (n)
        3:   check_eq("sclk_hi@3", 32'(bus.sample_clk), 32'h1);
        4:   check_eq("sclk_lo@4", 32'(bus.sample_clk), 32'h0);
        7:   check_eq("data@7", 32'(bus.data_outs), 32'h00);
        8:   begin
               check_eq("data@8", 32'(bus.data_outs), 32'h02);
               check_eq("sclk_rise@8", 32'(bus.sample_clk), 32'h1);
             end
        16:  begin
               check_eq("data@16", 32'(bus.data_outs), 32'h02);
               bus.bitslip = 1'b1;
             end
        24:  begin
               check_eq("data@24", 32'(bus.data_outs), 32'h02);
               bus.bitslip = 1'b0;
             end
        25:  check_eq("sclk_hold@25", 32'(bus.sample_clk), 32'h1);
        28:  check_eq("sclk_slip@28", 32'(bus.sample_clk), 32'h1);
        32:  check_eq("data@32", 32'(bus.data_outs), 32'h02);
        33:  check_eq("slip1@33", 32'(bus.data_outs), 32'h04);
        41:  check_eq("slip1@41", 32'(bus.data_outs), 32'h04);
        96:  bus.bitslip = 1'b1;
        104: bus.bitslip = 1'b0;
        113: check_eq("data@113", 32'(bus.data_outs), 32'h04);
        114: check_eq("slip2@114", 32'(bus.data_outs), 32'h08);
        176: bus.bitslip = 1'b1;
        184: bus.bitslip = 1'b0;
        194: check_eq("data@194", 32'(bus.data_outs), 32'h08);
        195: check_eq("slip3@195", 32'(bus.data_outs), 32'h10);
        200: bus.bitslip = 1'b1;
        211: check_eq("data@211", 32'(bus.data_outs), 32'h10);
        212: check_eq("held@212", 32'(bus.data_outs), 32'h20);
        240: bus.bitslip = 1'b0;
        260: check_eq("held@260", 32'(bus.data_outs), 32'h20);
        default: ;
      endcase
    end

    // Reset with a slip pending: no rotation may follow the release.
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      b = (((n - 1) % 8) == 6);
      send_bit(b, b);
      if (n == 8) check_eq("pre_rst@8", 32'(bus.data_outs), 32'h02);
      if (n == 16) bus.bitslip = 1'b1;
    end
    pll_reset_n = 1'b0;
    #1;
    check_eq("async_rst_data", 32'(bus.data_outs), 32'h00);
    check_eq("async_rst_sclk", 32'(bus.sample_clk), 32'h0);
    bus.bitslip = 1'b0;
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      b = (((n - 1) % 8) == 6);
      send_bit(b, b);
    end
    check_eq("no_slip@24", 32'(bus.data_outs), 32'h02);

    // Equal legs decode as 0.
    do_reset();
    leg_eq = 1'b1;
    for (int n = 1; n <= 8; n++) send_bit(1'b1, 1'b1);
    check_eq("leg_eq", 32'(bus.data_outs), 32'h00);
    leg_eq = 1'b0;
    for (int n = 1; n <= 8; n++) send_bit(1'b1, 1'b1);
    check_eq("leg_diff", 32'(bus.data_outs), 32'hff);

    // Auto phase: mid sample equal to previous bit votes +1.
    bus.id_auto_control = 1'b1;
    bus.pd_int_period   = 32'd64;
    do_reset();
    prev = 1'b0;
    for (int n = 1; n <= 134; n++) begin
      b = n[0];
      send_bit(b, prev);
      prev = b;
      if (n == 70)  check_eq("auto_up@70", 32'(bus.id_value), 32'd17);
      if (n == 134) check_eq("auto_up@134", 32'(bus.id_value), 32'd18);
    end

    // Mid sample equal to the new bit votes -1.
    do_reset();
    for (int n = 1; n <= 70; n++) begin
      b = n[0];
      send_bit(b, b);
    end
    check_eq("auto_down", 32'(bus.id_value), 32'd15);

    // Constant data: no transitions, no tap movement.
    do_reset();
    for (int n = 1; n <= 140; n++) send_bit(1'b0, 1'b0);
    check_eq("auto_const", 32'(bus.id_value), 32'd16);

    // Short windows drive the tap into its upper limit.
    bus.pd_int_period = 32'd2;
    do_reset();
    prev = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      b = n[0];
      send_bit(b, prev);
      prev = b;
    end
    check_eq("auto_sat31", 32'(bus.id_value), 32'd31);

    // A zero period behaves as a one-bit window.
    bus.pd_int_period = 32'd0;
    do_reset();
    prev = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      b = n[0];
      send_bit(b, prev);
      prev = b;
    end
    check_eq("auto_period0", 32'(bus.id_value), 32'd26);

    // Manual control.
    bus.id_auto_control = 1'b0;
    bus.pd_int_period   = 32'd64;
    do_reset();
    set_lane(1'b0);
    repeat (3) pulse_id(1'b1, 1'b0);
    check_eq("man_inc3", 32'(bus.id_value), 32'd19);
    pulse_id(1'b0, 1'b1);
    check_eq("man_dec1", 32'(bus.id_value), 32'd18);
    pulse_id(1'b1, 1'b1);
    check_eq("man_both", 32'(bus.id_value), 32'd18);
    repeat (18) pulse_id(1'b0, 1'b1);
    check_eq("man_zero", 32'(bus.id_value), 32'd0);
    pulse_id(1'b0, 1'b1);
    check_eq("man_floor", 32'(bus.id_value), 32'd0);
    bus.id_mux = 1'b1;
    #1;
    check_eq("mux_absent", 32'(bus.id_value), 32'd0);
    pulse_id(1'b1, 1'b0);
    bus.id_mux = 1'b0;
    #1;
    check_eq("mux_absent_inc", 32'(bus.id_value), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
